// File: rtl/brick_health_store.sv
// brick_health_store: per-brick health memory with load capture,
// collision query port, hit arbiter and redraw request output.
module brick_health_store #(
    parameter int BRICK_NUM = 128
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_we,
    input  logic [9:0] load_addr,
    input  logic [1:0] load_health,
    input  logic       load_done,
    input  logic [9:0] query_addr,
    output logic [1:0] query_health,
    input  logic       hit_req,
    input  logic [9:0] hit_addr,
    output logic       hit_ack,
    output logic       hit_alive,
    output logic       redraw_valid,
    output logic [9:0] redraw_addr,
    output logic [1:0] redraw_health,
    input  logic       redraw_ready,
    output logic [9:0] hp_remaining,
    output logic       playing,
    output logic       level_clear
);

    localparam int AW = (BRICK_NUM > 1) ? $clog2(BRICK_NUM) : 1;
    localparam logic [10:0] NUM = 11'(BRICK_NUM);

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_READ,
        S_UPDATE,
        S_REDRAW
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] mem_q [BRICK_NUM];
    logic [1:0] mem_d [BRICK_NUM];
    logic [9:0] hp_q, hp_d;
    logic [1:0] query_q, query_d;
    logic [9:0] addr_q, addr_d;
    logic [1:0] entry_q, entry_d;

    logic q_in, l_in, h_in;

    // address range checks for the three access paths
    always_comb begin
        q_in = ({1'b0, query_addr} < NUM);
        l_in = ({1'b0, load_addr} < NUM);
        h_in = ({1'b0, hit_addr} < NUM);
    end

    // next-state, memory write port, running total and outputs
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        hp_d    = hp_q;
        addr_d  = addr_q;
        entry_d = entry_q;
        query_d = q_in ? mem_q[query_addr[AW-1:0]] : 2'd0;

        hit_ack       = 1'b0;
        hit_alive     = 1'b0;
        redraw_valid  = 1'b0;
        redraw_addr   = 10'd0;
        redraw_health = 2'd0;

        unique case (state_q)
            S_LOAD: begin
                if (load_we && l_in) begin
                    mem_d[load_addr[AW-1:0]] = load_health;
                    hp_d = hp_q
                         - {8'd0, mem_q[load_addr[AW-1:0]]}
                         + {8'd0, load_health};
                end
                if (load_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (hit_req) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                addr_d  = hit_addr;
                entry_d = h_in ? mem_q[hit_addr[AW-1:0]] : 2'd0;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                hit_ack = 1'b1;
                if (entry_q != 2'd0) begin
                    hit_alive = 1'b1;
                    mem_d[addr_q[AW-1:0]] = entry_q - 2'd1;
                    hp_d    = hp_q - 10'd1;
                    state_d = S_REDRAW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDRAW: begin
                redraw_valid  = 1'b1;
                redraw_addr   = addr_q;
                redraw_health = entry_q - 2'd1;
                if (redraw_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_LOAD;
        endcase

        query_health = query_q;
        hp_remaining = hp_q;
        playing      = (state_q != S_LOAD);
        level_clear  = playing && (hp_q == 10'd0);
    end

    // state, memory and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_LOAD;
            hp_q    <= '0;
            query_q <= '0;
            addr_q  <= '0;
            entry_q <= '0;
            for (int i = 0; i < BRICK_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            query_q <= query_d;
            addr_q  <= addr_d;
            entry_q <= entry_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_brick_health_store.sv
// tb_brick_health_store: directed stimulus with a behavioural
// brick model checked every cycle plus literal expectations.
module tb_brick_health_store;

    localparam int N = 128;

    logic       clk = 1'b0;
    logic       resetn;
    logic       load_we;
    logic [9:0] load_addr;
    logic [1:0] load_health;
    logic       load_done;
    logic [9:0] query_addr;
    logic [1:0] query_health;
    logic       hit_req;
    logic [9:0] hit_addr;
    logic       hit_ack;
    logic       hit_alive;
    logic       redraw_valid;
    logic [9:0] redraw_addr;
    logic [1:0] redraw_health;
    logic       redraw_ready;
    logic [9:0] hp_remaining;
    logic       playing;
    logic       level_clear;

    always #5 clk = ~clk;

    brick_health_store #(.BRICK_NUM(N)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_health  (load_health),
        .load_done    (load_done),
        .query_addr   (query_addr),
        .query_health (query_health),
        .hit_req      (hit_req),
        .hit_addr     (hit_addr),
        .hit_ack      (hit_ack),
        .hit_alive    (hit_alive),
        .redraw_valid (redraw_valid),
        .redraw_addr  (redraw_addr),
        .redraw_health(redraw_health),
        .redraw_ready (redraw_ready),
        .hp_remaining (hp_remaining),
        .playing      (playing),
        .level_clear  (level_clear)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // behavioural model: brick healths, phase, and age of the hit in flight
    int mdl [N];
    bit m_play = 1'b0;
    int m_age = 0;
    int m_addr = 0;
    int exp_q = 0;
    bit started = 1'b0;

    function automatic bit inr(input int a);
        return a >= 0 && a < N;
    endfunction

    function automatic int rd(input int a);
        return inr(a) ? mdl[a] : 0;
    endfunction

    function automatic int sum_hp();
        int s = 0;
        foreach (mdl[i]) s += mdl[i];
        return s;
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (!resetn) begin
            foreach (mdl[i]) mdl[i] <= 0;
            m_play <= 1'b0;
            m_age  <= 0;
            exp_q  <= 0;
        end else begin
            exp_q <= rd(int'(query_addr));
            if (!m_play) begin
                if (load_we && inr(int'(load_addr)))
                    mdl[int'(load_addr)] <= int'(load_health);
                if (load_done) m_play <= 1'b1;
            end else begin
                case (m_age)
                    0: if (hit_req) begin
                        m_addr <= int'(hit_addr);
                        m_age  <= 1;
                    end
                    1: m_age <= 2;
                    2: if (rd(m_addr) > 0) begin
                        mdl[m_addr] <= mdl[m_addr] - 1;
                        m_age <= 3;
                    end else begin
                        m_age <= 0;
                    end
                    3: if (redraw_ready) m_age <= 0;
                    default: m_age <= 0;
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("m_hp", int'(hp_remaining), sum_hp());
                chk("m_playing", int'(playing), int'(m_play));
                chk("m_clear", int'(level_clear),
                    int'(m_play && sum_hp() == 0));
                chk("m_query", int'(query_health), exp_q);
                chk("m_ack", int'(hit_ack), int'(m_age == 2));
                if (m_age == 2)
                    chk("m_alive", int'(hit_alive), int'(rd(m_addr) > 0));
                chk("m_rvalid", int'(redraw_valid), int'(m_age == 3));
                if (m_age == 3) begin
                    chk("m_raddr", int'(redraw_addr), m_addr);
                    chk("m_rhealth", int'(redraw_health), mdl[m_addr]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int a, input int h);
        load_we     = 1'b1;
        load_addr   = 10'(a);
        load_health = 2'(h);
        cyc(1);
        load_we = 1'b0;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        load_done = 1'b0;
        load_we   = 1'b0;
        hit_req   = 1'b0;
        cyc(2);
        resetn = 1'b1;
    endtask

    task automatic hit(input int a, input int exp_alive,
                       input int exp_h, input int hold);
        int n = 0;
        hit_addr = 10'(a);
        hit_req  = 1'b1;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (hit_ack === 1'b1) break;
        end
        chk("ack_latency", n, 2);
        chk("ack_alive", int'(hit_alive), exp_alive);
        hit_req = 1'b0;
        cyc(1);
        chk("redraw_after_ack", int'(redraw_valid), exp_alive);
        if (exp_alive != 0) begin
            chk("redraw_addr", int'(redraw_addr), a);
            chk("redraw_health", int'(redraw_health), exp_h);
            if (hold > 0) begin
                hit_addr = 10'd18;
                hit_req  = 1'b1;
                repeat (hold) begin
                    cyc(1);
                    chk("hold_valid", int'(redraw_valid), 1);
                    chk("hold_addr", int'(redraw_addr), a);
                    chk("hold_health", int'(redraw_health), exp_h);
                    chk("hold_no_ack", int'(hit_ack), 0);
                end
                hit_req = 1'b0;
            end
            redraw_ready = 1'b1;
            cyc(1);
            redraw_ready = 1'b0;
            chk("redraw_done", int'(redraw_valid), 0);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        load_we      = 1'b0;
        load_addr    = '0;
        load_health  = '0;
        load_done    = 1'b0;
        query_addr   = 10'd17;
        hit_req      = 1'b0;
        hit_addr     = '0;
        redraw_ready = 1'b0;
        cyc(3);
        chk("rst_hp", int'(hp_remaining), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_query", int'(query_health), 0);
        chk("rst_redraw", int'(redraw_valid), 0);
        chk("rst_clear", int'(level_clear), 0);
        resetn = 1'b1;

        hit_addr = 10'd17;
        hit_req  = 1'b1;
        cyc(4);
        chk("load_no_ack", int'(hit_ack), 0);
        hit_req = 1'b0;

        load(17, 1);
        load(18, 2);
        load(19, 3);
        chk("hp_six", int'(hp_remaining), 6);
        load(17, 3);
        chk("hp_rewrite", int'(hp_remaining), 8);
        load(200, 3);
        chk("hp_oor_write", int'(hp_remaining), 8);

        load_done = 1'b1;
        cyc(1);
        chk("play_on", int'(playing), 1);
        chk("play_hp", int'(hp_remaining), 8);
        load(5, 3);
        chk("play_load_ignored", int'(hp_remaining), 8);

        query_addr = 10'd18;
        cyc(1);
        chk("query_18", int'(query_health), 2);
        query_addr = 10'd200;
        cyc(1);
        chk("query_oor", int'(query_health), 0);
        query_addr = 10'd19;

        hit(19, 1, 2, 5);
        chk("hp_after_19", int'(hp_remaining), 7);
        hit(5, 0, 0, 0);
        hit(200, 0, 0, 0);
        chk("hp_after_dead", int'(hp_remaining), 7);
        hit(17, 1, 2, 0);
        chk("hp_after_17", int'(hp_remaining), 6);

        do_reset();
        load_done = 1'b1;
        cyc(1);
        chk("empty_clear", int'(level_clear), 1);

        do_reset();
        query_addr  = 10'd40;
        load_we     = 1'b1;
        load_addr   = 10'd40;
        load_health = 2'd1;
        load_done   = 1'b1;
        cyc(1);
        load_we = 1'b0;
        chk("done_write_hp", int'(hp_remaining), 1);
        chk("done_write_clear", int'(level_clear), 0);
        hit(40, 1, 0, 0);
        chk("single_hp", int'(hp_remaining), 0);
        chk("single_clear", int'(level_clear), 1);

        do_reset();
        query_addr = 10'd10;
        load(10, 2);
        load_done = 1'b1;
        cyc(1);
        hit_addr = 10'd10;
        hit_req  = 1'b1;
        cyc(2);
        chk("mid_ack", int'(hit_ack), 1);
        hit_req = 1'b0;
        cyc(1);
        chk("mid_redraw", int'(redraw_valid), 1);
        resetn    = 1'b0;
        load_done = 1'b0;
        cyc(1);
        chk("mid_rst_redraw", int'(redraw_valid), 0);
        chk("mid_rst_playing", int'(playing), 0);
        chk("mid_rst_hp", int'(hp_remaining), 0);
        resetn = 1'b1;
        cyc(2);
        chk("mid_rst_query", int'(query_health), 0);
        chk("mid_rst_no_ack", int'(hit_ack), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
